// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: FSM states,
// command byte field positions, register count and frame check helper.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 1;
  localparam int CMD_ADDR_LSB = 0;
  localparam int REG_COUNT    = 4;

  // Bits [6:2] of the command byte are reserved and must be zero
  localparam logic [7:0] CMD_RSVD_MASK = 8'h7C;

  // A frame is good when the check byte closes the XOR over the frame
  // and no reserved command bit is set.
  function automatic logic frame_ok(input logic [7:0] cmd,
                                    input logic [7:0] data,
                                    input logic [7:0] chk,
                                    input logic [7:0] sync);
    return (chk == (cmd ^ data ^ sync)) && ((cmd & CMD_RSVD_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Bundle of the SPI receiver inputs and the register/tx/error outputs
// of the command controller.
interface spi_cmd_ctrl_if;
  import spi_cmd_pkg::*;

  logic                     iRxReady;
  logic [7:0]               iRx;
  logic                     iSPICS;
  logic [REG_COUNT*8-1:0]   oCfg;
  logic                     oRegWe;
  logic [1:0]               oRegAddr;
  logic [7:0]               oTxByte;
  logic                     oTxValid;
  logic                     oFrameErr;
  logic [7:0]               oErrCount;

  modport master (
    output iRxReady, iRx, iSPICS,
    input  oCfg, oRegWe, oRegAddr, oTxByte, oTxValid, oFrameErr, oErrCount
  );

  modport slave (
    input  iRxReady, iRx, iSPICS,
    output oCfg, oRegWe, oRegAddr, oTxByte, oTxValid, oFrameErr, oErrCount
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a history
// flop, producing a one-cycle pulse on each synchronized rising edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  // Resynchronize the input and keep one cycle of history for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= async_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: parses SYNC/CMD/DATA/CHK frames from the SPI
// receiver, writes or reads back four 8-bit config registers, and flags
// bad checksums, chip-select aborts and inter-byte timeouts.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input logic           sysclk,
  input logic           reset,
  spi_cmd_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic                          byte_stb;
  logic                          cs_abort;
  logic                          byte_vld;
  logic                          abort_vld;
  logic [7:0]                    byte_reg;
  logic [7:0]                    cmd_reg;
  logic [7:0]                    data_reg;
  logic [CNT_W-1:0]              tmo_cnt;
  state_t                        state;
  state_t                        state_next;
  logic                          cmd_ld;
  logic                          data_ld;
  logic                          we_next;
  logic                          rd_next;
  logic                          err_next;
  logic [REG_COUNT-1:0][7:0]     cfg_reg;
  logic [1:0]                    reg_addr;
  logic [7:0]                    tx_byte;
  logic                          reg_we;
  logic                          tx_valid;
  logic                          frame_err;
  logic [7:0]                    err_count;
  logic [1:0]                    cmd_addr;

  spi_sync_edge #(.RST_VAL(1'b0)) u_rx_sync (
    .clk      (sysclk),
    .reset    (reset),
    .async_in (bus.iRxReady),
    .rise     (byte_stb)
  );

  // Chip select idles high between frames, so its flops preset to 1
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk      (sysclk),
    .reset    (reset),
    .async_in (bus.iSPICS),
    .rise     (cs_abort)
  );

  assign cmd_addr = cmd_reg[CMD_ADDR_MSB:CMD_ADDR_LSB];

  // Capture the received byte and align strobe and abort one stage later
  always_ff @(posedge sysclk) begin
    if (reset) begin
      byte_reg  <= 8'h00;
      byte_vld  <= 1'b0;
      abort_vld <= 1'b0;
    end else begin
      byte_vld  <= byte_stb;
      abort_vld <= cs_abort;
      if (byte_stb) byte_reg <= bus.iRx;
    end
  end

  // State register, frame field latches and inter-byte timeout counter
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_reg  <= 8'h00;
      data_reg <= 8'h00;
      tmo_cnt  <= '0;
    end else begin
      state <= state_next;
      if (cmd_ld)  cmd_reg  <= byte_reg;
      if (data_ld) data_reg <= byte_reg;
      if (state == ST_IDLE || byte_vld) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Next state and result selection; abort beats byte beats timeout
  always_comb begin
    state_next = state;
    cmd_ld     = 1'b0;
    data_ld    = 1'b0;
    we_next    = 1'b0;
    rd_next    = 1'b0;
    err_next   = 1'b0;
    if (abort_vld && state != ST_IDLE) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end else if (byte_vld) begin
      case (state)
        ST_IDLE: if (byte_reg == SYNC_BYTE) state_next = ST_CMD;
        ST_CMD: begin
          cmd_ld     = 1'b1;
          state_next = ST_DATA;
        end
        ST_DATA: begin
          data_ld    = 1'b1;
          state_next = ST_CHK;
        end
        ST_CHK: begin
          state_next = ST_IDLE;
          if (frame_ok(cmd_reg, data_reg, byte_reg, SYNC_BYTE)) begin
            if (cmd_reg[CMD_WR_BIT]) we_next = 1'b1;
            else                     rd_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_cnt == CNT_W'(TIMEOUT_CYC)) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end
  end

  // Registered results: config writes, read-back, pulses and error count
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cfg_reg   <= '0;
      reg_addr  <= 2'd0;
      tx_byte   <= 8'h00;
      reg_we    <= 1'b0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      reg_we    <= we_next;
      tx_valid  <= rd_next;
      frame_err <= err_next;
      if (we_next) begin
        cfg_reg[cmd_addr] <= data_reg;
        reg_addr          <= cmd_addr;
      end
      if (rd_next) tx_byte <= cfg_reg[cmd_addr];
      if (err_next && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign bus.oCfg      = cfg_reg;
  assign bus.oRegWe    = reg_we;
  assign bus.oRegAddr  = reg_addr;
  assign bus.oTxByte   = tx_byte;
  assign bus.oTxValid  = tx_valid;
  assign bus.oFrameErr = frame_err;
  assign bus.oErrCount = err_count;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized scoreboard bench for spi_cmd_ctrl: stimulus pushes the
// expected outcome of each frame, a monitor pops it when a pulse appears.
module tb_spi_cmd_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 200;

  typedef enum int {EV_WR = 0, EV_RD = 1, EV_ERR = 2} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [1:0]  addr;
    logic [7:0]  val;
    logic [31:0] cfg;
    logic [7:0]  errs;
  } ev_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  ev_t        expq[$];
  logic [7:0] modelRegs [4];
  int         modelErrs   = 0;
  int         testsRun    = 0;
  int         testsFailed = 0;

  spi_cmd_ctrl_if bus();

  spi_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  // Free-running system clock
  always #5 sysclk = ~sysclk;

  // Overall time limit so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] modelCfg();
    return {modelRegs[3], modelRegs[2], modelRegs[1], modelRegs[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every result pulse must match the oldest pending expectation
  always @(negedge sysclk) begin
    ev_t      e;
    ev_kind_t seen;
    if (!reset && (bus.oRegWe || bus.oTxValid || bus.oFrameErr)) begin
      checkOutput("one_pulse", 32'(int'(bus.oRegWe) + int'(bus.oTxValid) + int'(bus.oFrameErr)), 32'd1);
      seen = bus.oFrameErr ? EV_ERR : (bus.oTxValid ? EV_RD : EV_WR);
      if (expq.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_event: got kind %0d, expected none", int'(seen));
      end else begin
        e = expq.pop_front();
        checkOutput("event_kind", 32'(int'(seen)), 32'(int'(e.kind)));
        checkOutput("cfg", bus.oCfg, e.cfg);
        case (e.kind)
          EV_WR:  checkOutput("reg_addr", 32'(bus.oRegAddr), 32'(e.addr));
          EV_RD:  checkOutput("tx_byte", 32'(bus.oTxByte), 32'(e.val));
          EV_ERR: checkOutput("err_count", 32'(bus.oErrCount), 32'(e.errs));
          default: ;
        endcase
      end
    end
  end

  task automatic pushEvent(input ev_kind_t k, input logic [1:0] a, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.val  = v;
    e.cfg  = modelCfg();
    e.errs = 8'(modelErrs);
    expq.push_back(e);
  endtask

  task automatic expectError();
    if (modelErrs < 255) modelErrs++;
    pushEvent(EV_ERR, 2'd0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge sysclk); #1;
    bus.iRx      = b;
    bus.iRxReady = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 bus.iRxReady = 1'b0;
    repeat (4) @(posedge sysclk);
  endtask

  task automatic raiseCs();
    @(posedge sysclk); #1 bus.iSPICS = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 bus.iSPICS = 1'b0;
    repeat (4) @(posedge sysclk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge sysclk);
      n++;
    end
    if (expq.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d events pending, expected 0", expq.size());
      expq.delete();
    end
    repeat (2) @(posedge sysclk);
  endtask

  // Full frame; the expected outcome follows directly from the frame rules
  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    logic       good;
    logic [1:0] a;
    good = (k == (c ^ d ^ SYNC)) && ((c & 8'h7C) == 8'h00);
    a    = c[1:0];
    sendByte(SYNC);
    sendByte(c);
    sendByte(d);
    if (good && c[7]) begin
      modelRegs[a] = d;
      pushEvent(EV_WR, a, d);
    end else if (good) begin
      pushEvent(EV_RD, a, modelRegs[a]);
    end else begin
      expectError();
    end
    sendByte(k);
    waitDrain(40);
  endtask

  task automatic doReset();
    @(posedge sysclk); #1 reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) modelRegs[i] = 8'h00;
    modelErrs = 0;
    expq.delete();
    @(negedge sysclk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_cfg", bus.oCfg, 32'h0);
    checkOutput("rst_addr", 32'(bus.oRegAddr), 32'h0);
    checkOutput("rst_tx", 32'(bus.oTxByte), 32'h0);
    checkOutput("rst_errs", 32'(bus.oErrCount), 32'h0);
    checkOutput("rst_we", 32'(bus.oRegWe), 32'h0);
    checkOutput("rst_txv", 32'(bus.oTxValid), 32'h0);
    checkOutput("rst_ferr", 32'(bus.oFrameErr), 32'h0);
  endtask

  initial begin
    logic [7:0] c, d, k, junk;
    bus.iRxReady = 1'b0;
    bus.iRx      = 8'h00;
    bus.iSPICS   = 1'b0;
    doReset();
    checkResetOutputs();

    // Directed frames
    applyStimulus(8'h81, 8'h40, 8'h64);
    checkOutput("reg1", 32'(bus.oCfg[15:8]), 32'h40);
    applyStimulus(8'h01, 8'h00, 8'hA4);
    applyStimulus(8'h82, 8'h10, 8'h00);
    applyStimulus(8'h85, 8'h10, 8'h30);

    // Non-sync byte and chip-select edge in IDLE are ignored
    sendByte(8'h12);
    raiseCs();
    waitDrain(10);

    // Inter-byte timeout after CMD, then a normal write
    sendByte(SYNC);
    sendByte(8'h81);
    expectError();
    repeat (TMO - 20) @(posedge sysclk);
    checkOutput("no_early_timeout", 32'(expq.size()), 32'd1);
    waitDrain(60);
    applyStimulus(8'h83, 8'h7F, 8'h59);
    checkOutput("reg3", 32'(bus.oCfg[31:24]), 32'h7F);

    // Chip select raised after the DATA byte
    sendByte(SYNC);
    sendByte(8'h80);
    sendByte(8'h55);
    expectError();
    raiseCs();
    waitDrain(20);

    // Randomized frames with occasional junk, reserved bits and bad checks
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = junk ^ 8'h01;
        sendByte(junk);
      end
      c = {1'($urandom_range(0, 1)), 5'd0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) c = c | (8'h04 << $urandom_range(0, 4));
      d = 8'($urandom);
      k = c ^ d ^ SYNC;
      if ($urandom_range(0, 5) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
      applyStimulus(c, d, k);
    end

    // Drive the error counter into saturation via aborted frames
    for (int n = 0; n < 300; n++) begin
      sendByte(SYNC);
      expectError();
      raiseCs();
      waitDrain(20);
    end
    checkOutput("err_sat", 32'(bus.oErrCount), 32'hFF);

    // Reset mid-frame discards the frame silently
    sendByte(SYNC);
    sendByte(8'h81);
    doReset();
    checkResetOutputs();
    repeat (TMO + 20) @(posedge sysclk);
    checkOutput("no_err_after_rst", 32'(bus.oErrCount), 32'h0);
    applyStimulus(8'h82, 8'h3C, 8'h82 ^ 8'h3C ^ SYNC);

    doReset();
    checkResetOutputs();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, maximum sysclk cycles allowed between bytes inside a frame.
REQ-003 SHALL have port sysclk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port iRxReady  in  1  byte-ready level from the SPI receiver, asynchronous to sysclk.
REQ-006 SHALL have port iRx  in  8  received byte; stable while iRxReady is high.
REQ-007 SHALL have port iSPICS  in  1  SPI chip select, active-low, asynchronous to sysclk.
REQ-008 SHALL have port oCfg  out  32  four 8-bit config registers; reg N at bits [8N+7:8N] (fan PWM duty values).
REQ-009 SHALL have port oRegWe  out  1  one-cycle pulse when a register is written.
REQ-010 SHALL have port oRegAddr  out  2  address of the last write.
REQ-011 SHALL have port oTxByte  out  8  read-back data for the future SPI transmitter.
REQ-012 SHALL have port oTxValid  out  1  one-cycle pulse when oTxByte is updated.
REQ-013 SHALL have port oFrameErr  out  1  one-cycle pulse on any frame error.
REQ-014 SHALL have port oErrCount  out  8  saturating frame-error count.

Function
REQ-015 SHALL pass iRxReady and iSPICS each through a 2-flop synchronizer plus a history flop; byte_stb = rising edge of synchronized iRxReady; cs_abort = rising edge of synchronized iSPICS.
REQ-016 SHALL capture iRx into a byte register in the cycle byte_stb is high; the frame is SYNC, CMD, DATA, CHK.
REQ-017 SHALL implement FSM states IDLE, CMD, DATA, CHK.
REQ-018 In IDLE, SHALL go to CMD on byte_stb with byte == SYNC_BYTE, and SHALL ignore any other byte without flagging an error.
REQ-019 CMD->DATA on byte_stb, latching the byte as cmd (bit7 = 1 write, 0 read; bits[3:0] = address).
REQ-020 DATA->CHK on byte_stb, latching the byte as data.
REQ-021 CHK->IDLE on byte_stb; the frame is valid iff the byte == cmd XOR data XOR SYNC_BYTE and cmd[3:2] == 0 and cmd[6:4] == 0.
REQ-022 A valid write SHALL update reg[cmd[1:0]] <= data, set oRegAddr, and pulse oRegWe in the cycle after the CHK byte_stb.
REQ-023 A valid read SHALL set oTxByte <= reg[cmd[1:0]] and pulse oTxValid in the cycle after the CHK byte_stb; data is don't-care but still enters the checksum.
REQ-024 An invalid CHK SHALL write nothing, pulse oFrameErr the next cycle, and return to IDLE.
REQ-025 A timeout counter SHALL clear on every byte_stb and in IDLE, and SHALL increment in CMD, DATA and CHK.
REQ-026 When the timeout counter reaches TIMEOUT_CYC, the FSM SHALL go to IDLE and pulse oFrameErr.
REQ-027 cs_abort while not in IDLE SHALL go to IDLE and pulse oFrameErr; cs_abort in IDLE SHALL have no effect.
REQ-028 Priority for simultaneous events SHALL be reset > cs_abort > byte_stb > timeout; a byte_stb in the timeout cycle is accepted and clears the counter.
REQ-029 oErrCount SHALL increment by 1 per oFrameErr pulse and hold at 8'hFF.
REQ-030 oRegWe, oTxValid and oFrameErr SHALL be registered and at most one SHALL be high in any cycle.
REQ-031 Latency from iRxReady rising (first sampling edge) to oRegWe/oTxValid/oFrameErr SHALL be exactly 4 sysclk edges; the SPI byte period SHALL be at least 8 sysclk cycles.

Reset
REQ-032 On reset, FSM SHALL go to IDLE, timeout counter and all synchronizer flops SHALL clear, and iSPICS synchronizer flops SHALL preset to 1.
REQ-033 On reset, oCfg, oRegAddr, oTxByte, oErrCount SHALL clear to 0, and oRegWe, oTxValid, oFrameErr SHALL clear to 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame without flagging an error.

Structure
REQ-035 Shared package spi_cmd_pkg SHALL hold the FSM state encoding, the CMD field positions (write bit 7, address [1:0]), and the register count of 4.
REQ-036 Sub-module spi_sync_edge (2-flop synchronizer plus rising-edge detect, reset value parameterized) SHALL be instantiated twice, once per asynchronous input.

Verification
REQ-037 Write frame A5,81,40,64 -> reg1 = 8'h40, oCfg[15:8] = 8'h40, oRegWe pulse, oRegAddr = 1, oErrCount = 0.
REQ-038 After REQ-037, read frame A5,01,00,A4 -> oTxByte = 8'h40, oTxValid pulse, oCfg unchanged.
REQ-039 Frame A5,82,10,00 (bad checksum) -> no write, oFrameErr pulse, oErrCount = 1.
REQ-040 Frame A5,85,10,30 (address bits[3:2] != 0) -> oFrameErr pulse, no write.
REQ-041 A5,81 then idle TIMEOUT_CYC cycles -> oFrameErr pulse, FSM in IDLE; then A5,83,7F,59 -> reg3 = 8'h7F.
REQ-042 iSPICS raised after the DATA byte -> oFrameErr pulse; force 300 errors -> oErrCount = 8'hFF; reset -> all outputs 0.
